// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; checks each resolve against its prediction, flushes on mispredict.
// Latency: resolve sampled at edge N gives flush/redirect/bht update registered in cycle N+1, one cycle wide.
// Backpressure: push_ready low when full (registered occupancy); pushes while full are dropped and flagged in err.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int LOWER = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [PC_W-1:0]            push_pc,
    input  logic                       push_pred_taken,
    input  logic [PC_W-1:0]            push_pred_target,
    output logic                       push_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       bht_en,
    output logic [LOWER-1:0]           bht_write_addr,
    output logic                       bht_was_taken,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                mispredicts,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              flush_q, flush_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic              bht_en_q, bht_en_d;
    logic [LOWER-1:0]  bht_write_addr_q, bht_write_addr_d;
    logic              bht_was_taken_q, bht_was_taken_d;
    logic [15:0]       mispredicts_q, mispredicts_d;
    logic              err_q, err_d;

    entry_t head_e;
    logic   empty, full, res_fire, mispred, push_fire;

    assign head_e    = mem_q[head_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign res_fire  = res_valid & ~empty;
    // Target only matters when both sides agree the branch was taken.
    assign mispred   = res_fire & ((res_taken != head_e.pred_taken) |
                                   (res_taken & head_e.pred_taken & (res_target != head_e.pred_target)));
    assign push_fire = push_valid & ~full & ~mispred;

    always_comb begin
        mem_d            = mem_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        flush_d          = 1'b0;
        redirect_pc_d    = '0;
        bht_en_d         = 1'b0;
        bht_write_addr_d = '0;
        bht_was_taken_d  = 1'b0;
        mispredicts_d    = mispredicts_q;
        err_d            = err_q | (push_valid & full) | (res_valid & empty);

        if (mispred) begin
            // Everything younger than the head is wrong-path.
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            flush_d       = 1'b1;
            redirect_pc_d = res_taken ? res_target : head_e.pc + PC_W'(4);
            if (mispredicts_q != 16'hFFFF) begin
                mispredicts_d = mispredicts_q + 16'd1;
            end
        end else begin
            if (push_fire) begin
                mem_d[tail_q] = '{pc: push_pc, pred_taken: push_pred_taken,
                                  pred_target: push_pred_target};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (res_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_fire) - CNT_W'(res_fire);
        end

        if (res_fire) begin
            bht_en_d         = 1'b1;
            bht_write_addr_d = head_e.pc[LOWER+1:2];
            bht_was_taken_d  = res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            bht_en_q         <= 1'b0;
            bht_write_addr_q <= '0;
            bht_was_taken_q  <= 1'b0;
            mispredicts_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            mem_q            <= mem_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            bht_en_q         <= bht_en_d;
            bht_write_addr_q <= bht_write_addr_d;
            bht_was_taken_q  <= bht_was_taken_d;
            mispredicts_q    <= mispredicts_d;
            err_q            <= err_d;
        end
    end

    assign push_ready     = ~full;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign bht_en         = bht_en_q;
    assign bht_write_addr = bht_write_addr_q;
    assign bht_was_taken  = bht_was_taken_q;
    assign count          = count_q;
    assign mispredicts    = mispredicts_q;
    assign err            = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: queue-based reference model, decoupled monitor.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int LOWER = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push_valid = 1'b0;
    logic [PC_W-1:0]   push_pc = '0;
    logic              push_pred_taken = 1'b0;
    logic [PC_W-1:0]   push_pred_target = '0;
    logic              push_ready;
    logic              res_valid = 1'b0;
    logic              res_taken = 1'b0;
    logic [PC_W-1:0]   res_target = '0;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic              bht_en;
    logic [LOWER-1:0]  bht_write_addr;
    logic              bht_was_taken;
    logic [2:0]        count;
    logic [15:0]       mispredicts;
    logic              err;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .LOWER(LOWER)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
        .push_pred_target(push_pred_target), .push_ready(push_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .redirect_pc(redirect_pc), .bht_en(bht_en),
        .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
        .count(count), .mispredicts(mispredicts), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit pt; logic [31:0] tgt; } ent_t;
    typedef struct { bit flush; logic [31:0] rpc; logic [4:0] addr; bit taken; } res_t;
    typedef struct { bit bht_en; bit flush; int count; bit err; int mis; bit ready; } st_t;

    ent_t mq[$];
    res_t exp_res[$];
    st_t  exp_st[$];
    bit   m_err;
    int   m_mis;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle: drive at negedge, advance the reference model, queue what the DUT must show after the edge.
    task automatic step(input bit r, input bit pv, input logic [31:0] ppc, input bit pt,
                        input logic [31:0] ptgt, input bit rv, input bit rt, input logic [31:0] rtgt);
        st_t  s;
        res_t x;
        ent_t e;
        bit   mis;
        bit   fired;
        bit   was_full;
        mis = 1'b0;
        fired = 1'b0;
        @(negedge clk);
        rst = r; push_valid = pv; push_pc = ppc; push_pred_taken = pt; push_pred_target = ptgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        if (r) begin
            mq.delete();
            m_err = 1'b0;
            m_mis = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (rv) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    e = mq.pop_front();
                    fired = 1'b1;
                    mis = (rt != e.pt) || (rt && e.tgt != rtgt);
                    x.flush = mis;
                    x.rpc = rt ? rtgt : e.pc + 32'd4;
                    x.addr = e.pc[6:2];
                    x.taken = rt;
                    exp_res.push_back(x);
                    if (mis) begin
                        mq.delete();
                        if (m_mis < 65535) m_mis++;
                    end
                end
            end
            if (pv) begin
                if (was_full) m_err = 1'b1;
                else if (!mis) mq.push_back('{pc: ppc, pt: pt, tgt: ptgt});
            end
        end
        s.bht_en = fired;
        s.flush = mis;
        s.count = mq.size();
        s.err = m_err;
        s.mis = m_mis;
        s.ready = (mq.size() != DEPTH);
        exp_st.push_back(s);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
        step(0, 1, pc, pt, tgt, 0, 0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 1, rt, tgt);
    endtask

    // Monitor: compares the DUT against the scoreboard one time unit after each rising edge.
    initial begin
        st_t  s;
        res_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_st.size() > 0) begin
                s = exp_st.pop_front();
                chk("count", count, s.count);
                chk("push_ready", push_ready, s.ready);
                chk("err", err, s.err);
                chk("mispredicts", mispredicts, s.mis);
                chk("bht_en", bht_en, s.bht_en);
                chk("flush", flush, s.flush);
                if (s.bht_en && exp_res.size() > 0) begin
                    x = exp_res.pop_front();
                    chk("bht_write_addr", bht_write_addr, x.addr);
                    chk("bht_was_taken", bht_was_taken, x.taken);
                    if (x.flush) chk("redirect_pc", redirect_pc, x.rpc);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc, tgt, rtgt;
        bit pt, rt, pv, rv;

        // Reset held with a push request present.
        step(1, 1, 32'h500, 0, 0, 0, 0, 0);
        step(1, 1, 32'h504, 0, 0, 1, 1, 32'h8);
        idle();

        // Correct taken prediction.
        push(32'h100, 1, 32'h80);
        resolve(1, 32'h80);
        idle();

        // Direction mispredict, with a push in the resolve cycle that must be dropped.
        push(32'h40, 0, 0);
        push(32'h44, 0, 0);
        push(32'h48, 0, 0);
        step(0, 1, 32'h4C, 0, 0, 1, 1, 32'h200);
        idle();

        // Not-taken mispredict: redirect to pc+4.
        push(32'h7C, 1, 32'h10);
        resolve(0, 0);
        idle();

        // Target mispredict: both taken, targets differ.
        push(32'h20, 1, 32'h1000);
        resolve(1, 32'h2000);

        // Fill, overflow, then sustained push+resolve across the pointer wrap.
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 0, 0);
        push(32'h3F0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 32'h400 + 32'(i * 4), 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) resolve(0, 0);

        // Underflow after reset clears err.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        resolve(1, 32'h44);
        idle();

        // Reset mid-operation discards entries.
        push(32'h600, 1, 32'h700);
        push(32'h604, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        resolve(0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 50);
            pc = {20'h0, 10'($urandom), 2'b00};
            pt = $urandom_range(0, 1);
            tgt = 32'h100 * $urandom_range(0, 3);
            rt = $urandom_range(0, 1);
            rtgt = 32'h100 * $urandom_range(0, 3);
            if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
                rt = mq[0].pt;
                rtgt = mq[0].tgt;
            end
            step(($urandom_range(0, 299) == 0), pv, pc, pt, tgt, rv, rt, rtgt);
        end

        // Saturation: preload the counter near the top, then mispredict past it.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        force dut.mispredicts_q = 16'hFFF8;
        #1;
        release dut.mispredicts_q;
        m_mis = 16'hFFF8;
        for (int i = 0; i < 12; i++) begin
            push(32'h80 + 32'(i * 4), 0, 0);
            resolve(1, 32'h900);
        end
        idle();
        idle();

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
